// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux select arbiter.
package mux_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  // Winner is the first set request searching upward from last+1 with wrap.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] w_idx;
    logic [SEL_W-1:0] w_win;
    w_win = last + 2'd1;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = last + 2'd1 + k[SEL_W-1:0];
      if (req[w_idx]) begin
        w_win = w_idx;
      end else begin
        w_win = w_win;
      end
    end
    return w_win;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate requests so last+1 is bit 0,
// find the first set bit, then rotate the index back.
module rr_priority_pick
  import mux_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       any_req
);

  logic [1:0] w_start;
  logic [3:0] w_rot;
  logic [1:0] w_ofs;
  logic [1:0] w_idx;

  assign w_start = last + 2'd1;

  // Rotate so the search origin lands on bit 0.
  always_comb begin
    w_rot = 4'b0000;
    w_idx = 2'd0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx    = w_start + k[1:0];
      w_rot[k] = req[w_idx];
    end
  end

  // Find-first on the rotated vector.
  always_comb begin
    w_ofs = 2'd0;
    if (w_rot[0]) begin
      w_ofs = 2'd0;
    end else if (w_rot[1]) begin
      w_ofs = 2'd1;
    end else if (w_rot[2]) begin
      w_ofs = 2'd2;
    end else begin
      w_ofs = 2'd3;
    end
  end

  assign winner  = w_start + w_ofs;
  assign any_req = |req;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 mux; holds each grant until
// done, request drop or hold timeout, with a one-cycle bubble between grants.
module mux_sel_arbiter #(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic [3:0] gnt,
  output logic       timeout
);

  import mux_arb_pkg::*;

  if (N_REQ != 4) begin : g_bad_n_req
    $error("mux_sel_arbiter: N_REQ must be 4");
  end
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux_sel_arbiter: HOLD_MAX must be in 1..255");
  end
  if ((64'd1 << CNT_W) <= HOLD_MAX) begin : g_bad_cnt_w
    $error("mux_sel_arbiter: CNT_W too narrow for HOLD_MAX");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [3:0]       r_gnt;
  logic [3:0]       w_gnt_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_last;
  logic [1:0]       w_last_nxt;

  logic [1:0]       w_winner;
  logic             w_any_req;
  logic             w_rel_done;
  logic             w_rel_drop;
  logic             w_rel_hold;

  rr_priority_pick u_pick (
    .req     (req),
    .last    (r_last),
    .winner  (w_winner),
    .any_req (w_any_req)
  );

  assign w_rel_done = done;
  assign w_rel_drop = ~req[r_sel];
  assign w_rel_hold = (r_cnt == CNT_LAST);

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sel     <= 2'b00;
      r_valid   <= 1'b0;
      r_gnt     <= 4'b0000;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_last    <= 2'b11;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_valid   <= w_valid_nxt;
      r_gnt     <= w_gnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, count and watch release causes in GRANT.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_valid_nxt   = r_valid;
    w_gnt_nxt     = r_gnt;
    w_timeout_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_last_nxt    = r_last;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_winner;
          w_valid_nxt = 1'b1;
          w_gnt_nxt   = onehot(w_winner);
          w_cnt_nxt   = '0;
        end else begin
          w_valid_nxt = 1'b0;
          w_gnt_nxt   = 4'b0000;
        end
      end
      GRANT: begin
        if (w_rel_done || w_rel_drop || w_rel_hold) begin
          w_state_nxt   = IDLE;
          w_last_nxt    = r_sel;
          w_valid_nxt   = 1'b0;
          w_gnt_nxt     = 4'b0000;
          w_cnt_nxt     = '0;
          // A timeout is only flagged when nothing else ended the grant.
          w_timeout_nxt = w_rel_hold & ~w_rel_done & ~w_rel_drop;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_gnt_nxt   = 4'b0000;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign sel       = r_sel;
  assign sel_valid = r_valid;
  assign gnt       = r_gnt;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// random traffic compared every cycle against a queue-free behavioural model.
module tb_mux_sel_arbiter;

  localparam int HOLD_MAX = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic       sel_valid;
  logic [3:0] gnt;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  mux_sel_arbiter #(.N_REQ(4), .HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .sel_valid (sel_valid),
    .gnt       (gnt),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: cur = granted source or -1, held = granted cycles so far,
  // last = previous winner, to = timeout flag shown this cycle.
  typedef struct {
    int cur;
    int held;
    int last;
    bit to;
  } mstate_t;

  mstate_t ms;

  function automatic mstate_t step(mstate_t m, logic [3:0] r, logic d);
    mstate_t n;
    bit      rel;
    int      c;
    n    = m;
    n.to = 1'b0;
    if (m.cur < 0) begin
      if (r != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m.last + k) % 4;
          if (r[c]) begin
            n.cur  = c;
            n.held = 1;
            break;
          end
        end
      end
    end else begin
      rel = d || !r[m.cur] || (m.held == HOLD_MAX);
      if (rel) begin
        n.to   = (m.held == HOLD_MAX) && !d && r[m.cur];
        n.last = m.cur;
        n.cur  = -1;
        n.held = 0;
      end else begin
        n.held = m.held + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms <= '{-1, 0, 3, 1'b0};
    else        ms <= step(ms, req, done);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_sel_valid", {31'd0, sel_valid}, {31'd0, ms.cur >= 0});
      chk("model_gnt", {28'd0, gnt}, (ms.cur >= 0) ? (32'd1 << ms.cur) : 32'd0);
      chk("model_timeout", {31'd0, timeout}, {31'd0, ms.to});
      if (ms.cur >= 0) chk("model_sel", {30'd0, sel}, ms.cur);
    end
  end

  task automatic wait_grant(input string nm);
    int n;
    n = 0;
    while (!sel_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sel_valid) begin
      n_errors++;
      $display("FAIL %s: no grant within 20 cycles", nm);
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  int seq_exp [5] = '{0, 1, 2, 3, 0};
  int hold_cnt;

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", {28'd0, gnt}, 32'd0);
    chk("reset_valid", {31'd0, sel_valid}, 32'd0);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);
    chk("reset_sel", {30'd0, sel}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All request; done two cycles into each grant.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wait_grant("rr_seq_grant");
      chk("rr_seq_sel", {30'd0, sel}, seq_exp[i]);
      chk("rr_seq_gnt", {28'd0, gnt}, 32'd1 << seq_exp[i]);
      @(negedge clk);
      pulse_done();
      chk("rr_bubble", {31'd0, sel_valid}, 32'd0);
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Single steady requester, no done: forced release after HOLD_MAX cycles.
    req = 4'b0100;
    @(negedge clk);
    wait_grant("hold_grant");
    hold_cnt = 0;
    while (gnt == 4'b0100 && hold_cnt < 30) begin
      hold_cnt++;
      @(negedge clk);
    end
    chk("hold_cycles", hold_cnt, 32'd8);
    chk("hold_timeout", {31'd0, timeout}, 32'd1);
    chk("hold_bubble", {31'd0, sel_valid}, 32'd0);
    @(negedge clk);
    chk("hold_regrant", {28'd0, gnt}, 32'h4);
    chk("hold_to_single", {31'd0, timeout}, 32'd0);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Requester drops after three cycles.
    req = 4'b0010;
    @(negedge clk);
    wait_grant("drop_grant");
    chk("drop_sel", {30'd0, sel}, 32'd1);
    repeat (2) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    chk("drop_valid", {31'd0, sel_valid}, 32'd0);
    chk("drop_timeout", {31'd0, timeout}, 32'd0);
    repeat (3) @(negedge clk);
    chk("drop_idle_gnt", {28'd0, gnt}, 32'd0);

    // last = 1, only source 0 requests: wrap-around search.
    req = 4'b0001;
    @(negedge clk);
    wait_grant("wrap_grant");
    chk("wrap_sel", {30'd0, sel}, 32'd0);
    pulse_done();
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a grant to source 3.
    req = 4'b1000;
    @(negedge clk);
    wait_grant("arst_grant");
    chk("arst_sel", {30'd0, sel}, 32'd3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", {28'd0, gnt}, 32'd0);
    chk("arst_valid", {31'd0, sel_valid}, 32'd0);
    req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wait_grant("arst_regrant");
    chk("arst_ptr_sel", {30'd0, sel}, 32'd0);
    pulse_done();
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // done coincides with the hold limit: normal release, no timeout.
    req = 4'b0100;
    @(negedge clk);
    wait_grant("both_grant");
    repeat (7) @(negedge clk);
    chk("both_still_granted", {28'd0, gnt}, 32'h4);
    pulse_done();
    chk("both_valid", {31'd0, sel_valid}, 32'd0);
    chk("both_timeout", {31'd0, timeout}, 32'd0);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      done = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    req  = 4'b0000;
    done = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
